// File: rtl/l2_mem_rsp_pkg.sv
// Shared constants, response-entry layout and helpers for the L2 backing-memory responder.
package l2_mem_rsp_pkg;
  localparam int DEF_BITADDR = 34;
  localparam int DEF_BITDATA = 512;
  localparam int DEF_BITSEQN = 16;
  localparam int DEF_XBITATR = 3;
  localparam int DEF_NUMWRDS = 256;
  localparam int DEF_BITWRDS = 8;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_FIFODEP = 8;

  localparam int ATTR_OOR = 0;

  typedef struct packed {
    logic [DEF_BITSEQN-1:0] seq;
    logic [DEF_BITDATA-1:0] dout;
    logic [DEF_XBITATR-1:0] attr;
  } rsp_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/l2_mem_rsp_fifo.sv
// Response FIFO with wrap-around pointers; the head entry lives in an output register.
module l2_mem_rsp_fifo #(
  parameter int W     = 531,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         stall,
  output logic         full,
  output logic         empty,
  output logic         head_vld,
  output logic [W-1:0] head_data,
  output logic         pop
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         head_vld_q, head_vld_d;
  logic [W-1:0] head_q, head_d;
  logic         store;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop       = head_vld_q & ~stall;
  assign head_vld  = head_vld_q;
  assign head_data = head_q;

  // The head register refills from storage first; an empty FIFO lets a push bypass straight into it.
  always_comb begin
    head_vld_d = head_vld_q;
    head_d     = head_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    store      = 1'b0;
    if (!head_vld_q || pop) begin
      if (!empty) begin
        head_vld_d = 1'b1;
        head_d     = mem_q[rd_q[PW-1:0]];
        rd_d       = rd_q + 1'b1;
        store      = push;
      end else if (push) begin
        head_vld_d = 1'b1;
        head_d     = push_data;
      end else begin
        head_vld_d = 1'b0;
      end
    end else begin
      store = push;
    end
    if (store) wr_d = wr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[wr_q[PW-1:0]] <= push_data;
  end
endmodule

// File: rtl/l2_mem_responder.sv
// Backing-memory responder below the L2: posted line writes, fixed-latency in-order read responses.
// Define L2_MEM_RSP_OOR_EN to flag addresses >= NUMWRDS as out of range instead of wrapping them.
module l2_mem_responder
  import l2_mem_rsp_pkg::*;
#(
  parameter int BITADDR = DEF_BITADDR,
  parameter int BITDATA = DEF_BITDATA,
  parameter int BITSEQN = DEF_BITSEQN,
  parameter int XBITATR = DEF_XBITATR,
  parameter int NUMWRDS = DEF_NUMWRDS,
  parameter int BITWRDS = DEF_BITWRDS,
  parameter int LATENCY = DEF_LATENCY,
  parameter int FIFODEP = DEF_FIFODEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reqRd,
  input  logic               reqWr,
  input  logic [BITSEQN-1:0] reqSeq,
  input  logic [BITADDR-1:0] reqAddr,
  input  logic [BITDATA-1:0] reqDin,
  output logic               reqStall,
  output logic               rspVld,
  output logic [BITSEQN-1:0] rspSeq,
  output logic [BITDATA-1:0] rspDout,
  output logic [XBITATR-1:0] rspAttr,
  input  logic               rspStall
);
  localparam int ENTW = BITSEQN + BITDATA + XBITATR;
  localparam int CW   = cnt_width(FIFODEP);

  // Handshake: a request transfers on a posedge where (reqRd|reqWr) & !reqStall, and a response
  // transfers where rspVld & !rspStall; both sides hold their payload stable until it transfers.
  logic [BITDATA-1:0] mem_q [NUMWRDS];
  logic [BITWRDS-1:0] idx;
  logic               oor, rd_acc, wr_acc, pop;
  logic [BITDATA-1:0] rd_data;
  logic [XBITATR-1:0] rd_attr;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LATENCY-1:0]           pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0][ENTW-1:0] pipe_dat_q, pipe_dat_d;
  logic [ENTW-1:0]    head;
  logic               fifo_full_unused, fifo_empty_unused;

  assign idx = reqAddr[BITWRDS-1:0];
`ifdef L2_MEM_RSP_OOR_EN
  assign oor = (reqAddr >= BITADDR'(NUMWRDS));
`else
  logic [BITADDR-BITWRDS-1:0] addr_hi_unused;
  assign addr_hi_unused = reqAddr[BITADDR-1:BITWRDS];
  assign oor = 1'b0;
`endif

  // Credits count reads in the pipe plus the FIFO, so a full count bounds total occupancy.
  assign reqStall = (cnt_q == CW'(FIFODEP));
  assign rd_acc   = reqRd & ~reqStall;
  assign wr_acc   = reqWr & ~reqStall & ~oor;

  always_comb begin
    rd_attr = '0;
    if (oor) begin
      rd_data          = '0;
      rd_attr[ATTR_OOR] = 1'b1;
    end else if (reqWr) begin
      rd_data = reqDin;
    end else begin
      rd_data = mem_q[idx];
    end
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_dat_d    = '0;
    pipe_vld_d[0] = rd_acc;
    pipe_dat_d[0] = {reqSeq, rd_data, rd_attr};
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  always_comb begin
    case ({rd_acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      pipe_vld_q <= '0;
      pipe_dat_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_dat_q <= pipe_dat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[idx] <= reqDin;
  end

  l2_mem_rsp_fifo #(.W(ENTW), .DEPTH(FIFODEP)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_vld_q[LATENCY-1]),
    .push_data (pipe_dat_q[LATENCY-1]),
    .stall     (rspStall),
    .full      (fifo_full_unused),
    .empty     (fifo_empty_unused),
    .head_vld  (rspVld),
    .head_data (head),
    .pop       (pop)
  );

  assign {rspSeq, rspDout, rspAttr} = head;
endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench for l2_mem_responder: reference memory model feeds an expected queue,
// an independent monitor checks every popped response and output stability under rspStall.
module tb_l2_mem_responder;
  import l2_mem_rsp_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         reqRd, reqWr;
  logic [15:0]  reqSeq;
  logic [33:0]  reqAddr;
  logic [511:0] reqDin;
  logic         reqStall;
  logic         rspVld;
  logic [15:0]  rspSeq;
  logic [511:0] rspDout;
  logic [2:0]   rspAttr;
  logic         rspStall;

  int checks = 0;
  int errors = 0;

  rsp_entry_t   exp_q[$];
  logic [511:0] mem_m [256];
  bit           rand_done;

  l2_mem_responder dut (
    .clk(clk), .rst(rst), .reqRd(reqRd), .reqWr(reqWr), .reqSeq(reqSeq),
    .reqAddr(reqAddr), .reqDin(reqDin), .reqStall(reqStall), .rspVld(rspVld),
    .rspSeq(rspSeq), .rspDout(rspDout), .rspAttr(rspAttr), .rspStall(rspStall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference behaviour of one accepted request: write lands first, read sees the result.
  task automatic model_accept(input bit rd, input bit wr, input logic [15:0] seq,
                              input logic [33:0] addr, input logic [511:0] din);
    rsp_entry_t e;
    bit oor = 1'b0;
`ifdef L2_MEM_RSP_OOR_EN
    oor = (addr >= 34'd256);
`endif
    if (wr && !oor) mem_m[addr % 256] = din;
    if (rd) begin
      e.seq  = seq;
      e.dout = oor ? '0 : mem_m[addr % 256];
      e.attr = oor ? 3'b001 : 3'b000;
      exp_q.push_back(e);
    end
  endtask

  // Called and returns at posedge+#1; holds the request until it is accepted.
  task automatic send(input bit rd, input bit wr, input logic [15:0] seq,
                      input logic [33:0] addr, input logic [511:0] din);
    int  tries = 0;
    bit  done = 1'b0;
    bit  stalled;
    reqRd = rd; reqWr = wr; reqSeq = seq; reqAddr = addr; reqDin = din;
    while (!done) begin
      @(negedge clk);
      stalled = reqStall;
      @(posedge clk);
      if (!stalled) begin
        model_accept(rd, wr, seq, addr, din);
        done = 1'b1;
      end else if (++tries > 300) begin
        chk("send_timeout", 640'(tries), 640'(0));
        done = 1'b1;
      end
      #1;
    end
    reqRd = 1'b0; reqWr = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 640'(exp_q.size()), 640'(0));
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every transferred response and checks held outputs while stalled.
  logic         prev_hold = 1'b0;
  logic [639:0] prev_out;
  always @(negedge clk) begin
    rsp_entry_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("stall_hold", {rspVld, rspSeq, rspDout, rspAttr}, prev_out);
      if (rspVld && !rspStall) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {rspSeq, rspDout, rspAttr}, 640'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_entry", {rspSeq, rspDout, rspAttr}, 640'(e));
        end
      end
      prev_hold = rspVld && rspStall;
      prev_out  = {rspVld, rspSeq, rspDout, rspAttr};
    end
  end

  initial begin
    int vld_cnt;
    logic [511:0] d;
    rst = 1'b1; reqRd = 0; reqWr = 0; reqSeq = 0; reqAddr = 0; reqDin = 0; rspStall = 0;
    rand_done = 1'b0;

    @(negedge clk);
    chk("reset_outputs", {reqStall, rspVld, rspSeq, rspDout, rspAttr}, 640'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) send(1'b0, 1'b1, 16'h0, 34'(i), rand_line());

    // Write then read the same line; response lands LATENCY edges after the read is accepted.
    send(1'b0, 1'b1, 16'd1, 34'd3, {64{8'hA5}});
    send(1'b1, 1'b0, 16'd7, 34'd3, '0);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      chk("latency_rspvld", 640'(rspVld), 640'(i == 4));
    end
    @(posedge clk); #1;
    wait_drain();

    // Fill all credits with rspStall held, then release.
    rspStall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b0, 16'(100 + i), 34'($urandom_range(0, 255)), '0);
      if (i >= 6) chk("stall_after_reads", 640'(reqStall), 640'(i == 7));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_held_full", 640'(reqStall), 640'(1));
    end
    @(posedge clk); #1;
    rspStall = 1'b0;
    @(negedge clk);
    chk("stall_first_pop", 640'({reqStall, rspVld}), 640'(2'b11));
    @(negedge clk);
    chk("stall_released", 640'(reqStall), 640'(0));
    @(posedge clk); #1;
    wait_drain();

    // Simultaneous read+write returns the new data; out-of-range address handling.
    d = rand_line();
    send(1'b1, 1'b1, 16'd55, 34'd5, d);
    send(1'b1, 1'b0, 16'd56, 34'd5, '0);
    send(1'b1, 1'b0, 16'd57, 34'd300, '0);
    send(1'b0, 1'b1, 16'd58, 34'd301, rand_line());
    send(1'b1, 1'b0, 16'd59, 34'd45, '0);
    wait_drain();

    // Randomized traffic with random consumer backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          bit rd = 1'($urandom_range(0, 1));
          bit wr = 1'($urandom_range(0, 1));
          if (!rd && !wr) rd = 1'b1;
          send(rd, wr, 16'($urandom()),
               ($urandom_range(0, 9) == 0) ? 34'($urandom_range(256, 1023)) : 34'($urandom_range(0, 255)),
               rand_line());
          if ($urandom_range(0, 5) == 0) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rspStall = ($urandom_range(0, 3) == 0);
        end
      end
    join
    rspStall = 1'b0;
    @(posedge clk); #1;
    wait_drain();

    // Reset with reads in flight and buffered: everything is discarded.
    rspStall = 1'b1;
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 16'(200 + i), 34'(i), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_outputs", {reqStall, rspVld, rspSeq, rspDout, rspAttr}, 640'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    rspStall = 1'b0;
    vld_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rspVld) vld_cnt++;
    end
    chk("post_rst_no_rsp", 640'(vld_cnt), 640'(0));
    @(posedge clk); #1;
    send(1'b1, 1'b0, 16'd321, 34'd3, '0);
    wait_drain();
    chk("final_queue_empty", 640'(exp_q.size()), 640'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
